// File: rtl/pdp8_pkg.sv
// -----------------------------------------------------------------------------
// pdp8_pkg
// Shared definitions for the PDP-8/I processor model.
//   MS_W        width of the one-hot major-state vector
//   MS_F..MS_B  bit index of each major state within that vector
//   MS_FETCH    major-state value for Fetch (power-up / initialize state)
// Helper functions:
//   ms_prio_onehot  resolve a vector of next-state requests to one state
//   ms_multi_req    true when more than one request is present
// -----------------------------------------------------------------------------
package pdp8_pkg;

   localparam int MS_W  = 6;

   localparam int MS_F  = 0;
   localparam int MS_D  = 1;
   localparam int MS_E  = 2;
   localparam int MS_WC = 3;
   localparam int MS_CA = 4;
   localparam int MS_B  = 5;

   localparam logic [MS_W-1:0] MS_FETCH = 6'b000001;

   // Requests are ordered so that a higher bit index means higher priority
   // (B > CA > WC > E > D > F). The loop lets the highest asserted index win;
   // with no request at all the machine falls back to Fetch.
   function automatic logic [MS_W-1:0] ms_prio_onehot(input logic [MS_W-1:0] req);
      logic [MS_W-1:0] sel;
      sel = MS_FETCH;
      for (int i = 0; i < MS_W; i++) begin
         if (req[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
      return sel;
   endfunction

   function automatic logic ms_multi_req(input logic [MS_W-1:0] req);
      int n;
      n = 0;
      for (int i = 0; i < MS_W; i++) begin
         n += int'(req[i]);
      end
      return (n > 1);
   endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// -----------------------------------------------------------------------------
// pulse_sync_edge
// Synchronizes a timing-pulse level into the clk domain and produces a
// combinational rising-edge indication. All flops reset to 1, so a pulse that
// is already high when reset is released must first be seen low before an
// edge can be reported.
// Parameters:
//   STAGES   number of synchronizer flops (0..3); 0 uses pulse_i directly
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   pulse_i  timing-pulse level
//   rise_o   high for one cycle when the synchronized level goes 0 -> 1
// -----------------------------------------------------------------------------
module pulse_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pulse_i,
   output logic rise_o
);

   logic sync_s;
   logic dly_q;

   generate
      if (STAGES == 0) begin : g_direct
         assign sync_s = pulse_i;
      end else begin : g_sync
         logic [STAGES-1:0] sync_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '1;
            end else begin
               sync_q[0] <= pulse_i;
               for (int i = 1; i < STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign sync_s = sync_q[STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_q <= 1'b1;
      end else begin
         dly_q <= sync_s;
      end
   end

   assign rise_o = sync_s & ~dly_q;

endmodule

// File: rtl/major_state_reg.sv
// -----------------------------------------------------------------------------
// major_state_reg
// One-hot major-state register of the PDP-8/I (F, D, E, WC, CA, B). The state
// advances once per rising edge of TP4; the next state is chosen from the
// active-low set lines driven by the upstream AOI gates.
// Parameters:
//   SYNC_STAGES  synchronizer depth on tp4 (0..3)
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   tp4               TP4 level from the timing generator
//   init              synchronous initialize, forces Fetch
//   *_set_n           active-low next-state requests (F, D, E, WC, CA, B)
//   ms / ms_n         one-hot major state and its complement
//   tp4_edge          one-cycle strobe in the cycle after each state update
//   conflict          sticky: several set lines were asserted at an update
// -----------------------------------------------------------------------------
module major_state_reg
   import pdp8_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tp4,
   input  logic            init,
   input  logic            f_set_n,
   input  logic            d_set_n,
   input  logic            e_set_n,
   input  logic            wc_set_n,
   input  logic            ca_set_n,
   input  logic            b_set_n,
   output logic [MS_W-1:0] ms,
   output logic [MS_W-1:0] ms_n,
   output logic            tp4_edge,
   output logic            conflict
);

   logic            upd;
   logic [MS_W-1:0] req;

   logic [MS_W-1:0] ms_q,       ms_d;
   logic            conflict_q, conflict_d;
   logic            edge_q,     edge_d;

   pulse_sync_edge #(
      .STAGES  (SYNC_STAGES)
   ) u_tp4_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .pulse_i (tp4),
      .rise_o  (upd)
   );

   // Bit positions follow the major-state encoding so that the request
   // vector can be resolved straight into a one-hot state.
   always_comb begin
      req        = '0;
      req[MS_F]  = ~f_set_n;
      req[MS_D]  = ~d_set_n;
      req[MS_E]  = ~e_set_n;
      req[MS_WC] = ~wc_set_n;
      req[MS_CA] = ~ca_set_n;
      req[MS_B]  = ~b_set_n;
   end

   // init wins over a coincident update; that TP4 edge is simply dropped
   // while the edge pipeline keeps running.
   always_comb begin
      ms_d       = ms_q;
      conflict_d = conflict_q;
      edge_d     = upd;
      if (init) begin
         ms_d       = MS_FETCH;
         conflict_d = 1'b0;
         edge_d     = 1'b0;
      end else if (upd) begin
         ms_d = ms_prio_onehot(req);
         if (ms_multi_req(req)) begin
            conflict_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_q       <= MS_FETCH;
         conflict_q <= 1'b0;
         edge_q     <= 1'b0;
      end else begin
         ms_q       <= ms_d;
         conflict_q <= conflict_d;
         edge_q     <= edge_d;
      end
   end

   assign ms       = ms_q;
   assign ms_n     = ~ms_q;
   assign tp4_edge = edge_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_major_state_reg.sv
// -----------------------------------------------------------------------------
// tb_major_state_reg
// Directed scenarios followed by randomized TP4 / set-line / init stimulus.
// A reference model tracks TP4 samples as a history list and decides on each
// clock edge whether a rising TP4 edge has just emerged from the synchronizer
// delay, then applies the priority rule to the request lines.
// -----------------------------------------------------------------------------
module tb_major_state_reg;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tp4;
   logic       init;
   logic       f_set_n, d_set_n, e_set_n, wc_set_n, ca_set_n, b_set_n;
   logic [5:0] ms, ms_n;
   logic       tp4_edge;
   logic       conflict;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   bit         hist[$];
   logic [5:0] m_ms;
   logic       m_conf;
   logic       m_edge;

   always #5 clk = ~clk;

   major_state_reg #(
      .SYNC_STAGES (S)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tp4      (tp4),
      .init     (init),
      .f_set_n  (f_set_n),
      .d_set_n  (d_set_n),
      .e_set_n  (e_set_n),
      .wc_set_n (wc_set_n),
      .ca_set_n (ca_set_n),
      .b_set_n  (b_set_n),
      .ms       (ms),
      .ms_n     (ms_n),
      .tp4_edge (tp4_edge),
      .conflict (conflict)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Before reset release the level is taken as high, so a TP4 that is high
   // at release looks like no edge at all.
   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(1'b1);
      m_ms   = 6'b000001;
      m_conf = 1'b0;
      m_edge = 1'b0;
   endtask

   task automatic model_edge();
      bit         rose;
      int         nreq;
      logic [5:0] nxt;
      hist.push_front(tp4);
      void'(hist.pop_back());
      // hist[0] is the sample taken at this edge; the edge is acted on once
      // the 0->1 transition is S samples old.
      rose = hist[S] && !hist[S+1];
      if (init) begin
         m_ms   = 6'b000001;
         m_conf = 1'b0;
         m_edge = 1'b0;
      end else begin
         m_edge = rose;
         if (rose) begin
            nreq = int'(!b_set_n) + int'(!ca_set_n) + int'(!wc_set_n)
                 + int'(!e_set_n) + int'(!d_set_n) + int'(!f_set_n);
            if      (!b_set_n)  nxt = 6'b100000;
            else if (!ca_set_n) nxt = 6'b010000;
            else if (!wc_set_n) nxt = 6'b001000;
            else if (!e_set_n)  nxt = 6'b000100;
            else if (!d_set_n)  nxt = 6'b000010;
            else                nxt = 6'b000001;
            m_ms = nxt;
            if (nreq > 1) m_conf = 1'b1;
         end
      end
   endtask

   task automatic check_model();
      logic [5:0] exp_n;
      exp_n = ~m_ms;
      chk("ms",       ms,              m_ms);
      chk("ms_n",     ms_n,            exp_n);
      chk("onehot",   $countones(ms),  1);
      chk("tp4_edge", tp4_edge,        m_edge);
      chk("conflict", conflict,        m_conf);
   endtask

   // One clock: model follows the edge, outputs compared 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      #1;
      check_model();
   endtask

   task automatic lines_idle();
      f_set_n  = 1'b1; d_set_n  = 1'b1; e_set_n = 1'b1;
      wc_set_n = 1'b1; ca_set_n = 1'b1; b_set_n = 1'b1;
   endtask

   // Take tp4 low long enough to clear the pipeline, then raise it and run
   // until the update edge has passed. tp4 is left high.
   task automatic tp4_rise();
      tp4 = 1'b0;
      repeat (S + 2) cyc();
      tp4 = 1'b1;
      repeat (S + 1) cyc();
   endtask

   task automatic rand_inputs();
      f_set_n  = ($urandom_range(0, 3) != 0);
      d_set_n  = ($urandom_range(0, 3) != 0);
      e_set_n  = ($urandom_range(0, 3) != 0);
      wc_set_n = ($urandom_range(0, 3) != 0);
      ca_set_n = ($urandom_range(0, 3) != 0);
      b_set_n  = ($urandom_range(0, 3) != 0);
      init     = ($urandom_range(0, 49) == 0);
   endtask

   initial begin
      rst_n = 1'b0;
      tp4   = 1'b1;
      init  = 1'b0;
      lines_idle();
      model_reset();

      // reset with tp4 held high through release
      repeat (3) cyc();
      chk("rst_ms", ms, 6'b000001);
      chk("rst_ms_n", ms_n, 6'b111110);
      rst_n = 1'b1;
      repeat (10) cyc();
      chk("hold_hi_ms", ms, 6'b000001);
      chk("hold_hi_conf", conflict, 1'b0);
      $display("txn reset/tp4-high: ms=%b edge=%b conflict=%b", ms, tp4_edge, conflict);

      // latency: update on edge k+S, strobe for exactly one cycle after
      e_set_n = 1'b0;
      tp4 = 1'b0;
      repeat (S + 2) cyc();
      tp4 = 1'b1;
      cyc();
      chk("lat_k", ms, 6'b000001);
      cyc();
      chk("lat_k1", ms, 6'b000001);
      cyc();
      chk("lat_k2", ms, 6'b000100);
      chk("lat_strobe", tp4_edge, 1'b1);
      cyc();
      chk("lat_strobe_end", tp4_edge, 1'b0);
      chk("lat_hold", ms, 6'b000100);
      repeat (5) cyc();
      chk("no_reupd", ms, 6'b000100);
      $display("txn latency E: ms=%b edge=%b", ms, tp4_edge);

      // all lines idle from E -> Fetch
      lines_idle();
      tp4_rise();
      chk("idle_to_f", ms, 6'b000001);
      $display("txn idle from E: ms=%b", ms);

      // D and B together -> B with conflict, then F keeps conflict
      lines_idle();
      d_set_n = 1'b0; b_set_n = 1'b0;
      tp4_rise();
      chk("conf_ms", ms, 6'b100000);
      chk("conf_flag", conflict, 1'b1);
      $display("txn D+B: ms=%b conflict=%b", ms, conflict);
      lines_idle();
      f_set_n = 1'b0;
      tp4_rise();
      chk("sticky_ms", ms, 6'b000001);
      chk("sticky_flag", conflict, 1'b1);
      $display("txn F after conflict: ms=%b conflict=%b", ms, conflict);

      // init coincident with the update edge wins and drops that edge
      lines_idle();
      wc_set_n = 1'b0;
      tp4 = 1'b0;
      repeat (S + 2) cyc();
      tp4 = 1'b1;
      repeat (S) cyc();
      init = 1'b1;
      cyc();
      init = 1'b0;
      chk("init_ms", ms, 6'b000001);
      chk("init_conf", conflict, 1'b0);
      chk("init_edge", tp4_edge, 1'b0);
      cyc();
      chk("init_edge_next", tp4_edge, 1'b0);
      chk("init_lost", ms, 6'b000001);
      tp4_rise();
      chk("after_init_wc", ms, 6'b001000);
      $display("txn init+WC: ms=%b conflict=%b", ms, conflict);

      // asynchronous reset mid-operation, between clock edges
      lines_idle();
      ca_set_n = 1'b0; e_set_n = 1'b0;
      tp4_rise();
      chk("pre_rst_ms", ms, 6'b010000);
      chk("pre_rst_conf", conflict, 1'b1);
      tp4 = 1'b0;
      repeat (S + 2) cyc();
      tp4 = 1'b1;
      cyc();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_ms", ms, 6'b000001);
      chk("async_conf", conflict, 1'b0);
      chk("async_edge", tp4_edge, 1'b0);
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (S + 4) cyc();
      chk("post_rst_ms", ms, 6'b000001);
      $display("txn async reset: ms=%b conflict=%b", ms, conflict);

      // randomized TP4 edges, set lines and occasional init
      for (int e = 0; e < 10000; e++) begin
         int lo;
         int hi;
         lo  = $urandom_range(1, 3);
         hi  = $urandom_range(1, 3);
         tp4 = 1'b0;
         repeat (lo) begin
            rand_inputs();
            cyc();
         end
         tp4 = 1'b1;
         repeat (hi) begin
            rand_inputs();
            cyc();
         end
         if ((e + 1) % 1000 == 0)
            $display("txn random edges=%0d: ms=%b conflict=%b", e + 1, ms, conflict);
      end
      init = 1'b0;
      lines_idle();
      repeat (4) cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/major_state_reg.md
Name: major_state_reg

Overview:
- Major-state register for the PDP-8/I processor model: holds the one-hot major state (Fetch, Defer, Execute, Word Count, Current Address, Break).
- Sits directly downstream of the AOI gate modules. Their active-low outputs are the next-state request lines.
- Advances on the rising edge of timing pulse TP4, modelled synchronously in the single clock domain.
- Feeds the major-state decode gating and the timing/memory control logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on tp4 before edge detection. Legal range 0..3; 0 means tp4 is used directly.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- tp4  in  1  TP4 level from the timing generator; the state advances on its rising edge
- init  in  1  synchronous initialize (power clear / START key); forces Fetch
- f_set_n  in  1  active-low request: next state Fetch
- d_set_n  in  1  active-low request: next state Defer
- e_set_n  in  1  active-low request: next state Execute
- wc_set_n  in  1  active-low request: next state Word Count
- ca_set_n  in  1  active-low request: next state Current Address
- b_set_n  in  1  active-low request: next state Break
- ms  out  6  one-hot major state: [0]=F, [1]=D, [2]=E, [3]=WC, [4]=CA, [5]=B
- ms_n  out  6  bitwise complement of ms (flip-flop 0-side outputs)
- tp4_edge  out  1  one-cycle strobe, high in the cycle after each state update
- conflict  out  1  sticky flag: more than one set line was asserted at an update

Behaviour:
- Reset (rst_n low, asynchronous):
  - ms=6'b000001 (Fetch), ms_n=6'b111110, tp4_edge=0, conflict=0.
  - Synchronizer flops and the delayed-tp4 flop reset to 1. A tp4 held high through reset release therefore produces no edge; tp4 must first be seen low.
- Edge detection:
  - tp4_s = tp4 after SYNC_STAGES flops.
  - tp4_d = tp4_s delayed one clock.
  - upd = tp4_s & ~tp4_d.
- Latency: ms updates on the (SYNC_STAGES+1)-th rising clk edge, counting the first edge that samples tp4 high. SYNC_STAGES=2 gives the 3rd edge; SYNC_STAGES=0 gives the same edge.
- Set-line sampling: the set lines are sampled on the update edge itself, with no synchronization (same clock domain).
- Next-state rule at an update:
  - Priority is B > CA > WC > E > D > F. The highest-priority asserted (low) request wins.
  - If no line is asserted, the next state is Fetch.
  - If two or more lines are asserted, conflict is set to 1. It stays 1 until init or reset.
- Hold: ms holds its value whenever upd=0 and init=0.
- tp4_edge: registered; equals upd from the previous cycle. It is exactly one clk wide per TP4 rising edge.
- init:
  - Has priority over upd in the same cycle.
  - Sets ms=Fetch, conflict=0, tp4_edge=0.
  - Does not clear the synchronizer/edge pipeline. A TP4 edge that coincides with init is lost; the next edge proceeds normally.
- Back-to-back edges: each TP4 rising edge yields exactly one update. tp4 high for many cycles causes no further updates.
- Output invariants: ms is always exactly one-hot, and ms_n == ~ms in every cycle.
- Reset mid-operation: the asynchronous clear takes effect immediately and no partial update survives.

Decomposition:
- Shared package (pdp8_pkg): MS_W=6; index constants MS_F=0, MS_D=1, MS_E=2, MS_WC=3, MS_CA=4, MS_B=5; constant MS_FETCH=6'b000001.
- One sub-module: pulse_sync_edge.
  - Parameterized synchronizer (SYNC_STAGES) plus rising-edge detector, with reset value 1.
  - Reused by other timing-pulse consumers.

Test Plan:
- Reset with tp4=1 held, release rst_n, keep tp4=1 for 10 cycles:
  - ms=000001, tp4_edge never asserts, conflict=0.
- SYNC_STAGES=2, e_set_n=0 (others 1), tp4 0->1 sampled at edge k:
  - ms=000100 after edge k+2.
  - tp4_edge=1 for exactly the following cycle.
- d_set_n=0 and b_set_n=0 together, then a TP4 edge:
  - ms=100000, conflict=1.
  - Later update with only f_set_n=0: ms=000001, conflict still 1.
- All set lines high, TP4 edge from state E (000100):
  - ms=000001.
- init=1 in the same cycle as upd with wc_set_n=0:
  - ms=000001, conflict=0, tp4_edge=0 next cycle.
  - Next TP4 edge with wc_set_n=0 gives ms=001000.
- Random stimulus, 10k TP4 edges:
  - Scoreboard: ms is one-hot, ms_n==~ms every cycle, and each update matches the priority rule.
